// File: rtl/calib_input_conditioner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// calib_input_conditioner
//
// Front-end conditioner for the calibration sequencer's two asynchronous opto
// inputs (frame-grabber and phase). For each input it:
//   * synchronises the raw pin into the clock domain,
//   * glitch-filters the synced signal, producing a clean level,
//   * emits a registered one-cycle strobe when the clean level goes 0->1.
// For the phase channel it also measures the number of cycles between
// successive rising strobes and runs a watchdog that flags loss of the
// phase signal.
//
// Ports
//   clock         in   1         system clock
//   reset_n       in   1         asynchronous active-low reset
//   fg_in         in   1         raw frame-grabber opto signal (async)
//   phase_in      in   1         raw phase opto signal (async)
//   fg_level      out  1         filtered frame-grabber level
//   fg_rise       out  1         one-cycle strobe on fg_level 0->1
//   phase_level   out  1         filtered phase level
//   phase_rise    out  1         one-cycle strobe on phase_level 0->1
//   period        out  PERIOD_W  cycles between the last two phase_rise strobes
//   period_valid  out  1         one-cycle strobe: period updated
//   period_sat    out  1         last reported period saturated
//   phase_lost    out  1         no phase rise for TIMEOUT cycles (sticky)
//
// There is no handshake on any port: strobes are single-cycle pulses that the
// consumer must sample every cycle; levels and period are plain registers.
// -----------------------------------------------------------------------------
module calib_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int PERIOD_W    = 24,
    parameter int TIMEOUT     = 2_000_000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                fg_in,
    input  logic                phase_in,
    output logic                fg_level,
    output logic                fg_rise,
    output logic                phase_level,
    output logic                phase_rise,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                period_sat,
    output logic                phase_lost
);

    // Channel index 0 is the frame-grabber input, index 1 is the phase input.
    localparam int CH_FG    = 0;
    localparam int CH_PHASE = 1;

    localparam int               CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    localparam int                LCNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [LCNT_W-1:0] LCNT_TOP = LCNT_W'(TIMEOUT);
    localparam logic [LCNT_W-1:0] LCNT_PRE = LCNT_W'(TIMEOUT - 1);

    localparam logic [PERIOD_W-1:0] PCNT_MAX = '1;
    localparam logic [PERIOD_W-1:0] PCNT_ONE = PERIOD_W'(1);

    // -------------------------------------------------------------------------
    // Synchroniser + glitch filter + rise strobe, both channels
    // -------------------------------------------------------------------------
    logic [1:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q   [2];
    logic [CNT_W-1:0]       filt_cnt [2];
    logic [1:0]             level_q;
    logic [1:0]             rise_q;
    logic [1:0]             synced;
    logic [1:0]             flip;
    logic                   phase_rise_evt;

    assign raw = {phase_in, fg_in};

    // A level flips on the FILTER_LEN-th consecutive cycle in which the synced
    // input disagrees with it; any agreeing cycle restarts the count.
    always_comb begin
        synced = '0;
        flip   = '0;
        for (int ch = 0; ch < 2; ch++) begin
            synced[ch] = sync_q[ch][SYNC_STAGES-1];
            flip[ch]   = (synced[ch] != level_q[ch]) && (filt_cnt[ch] == CNT_LAST);
        end
    end

    // The phase rise event is the edge at which phase_rise gets registered;
    // the watchdog reacts to it directly so phase_lost drops together with
    // the strobe.
    assign phase_rise_evt = flip[CH_PHASE] & ~level_q[CH_PHASE];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                sync_q[ch]   <= '0;
                filt_cnt[ch] <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                // Plain shift chain: no logic between synchroniser stages.
                sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
                rise_q[ch] <= flip[ch] & ~level_q[ch];
                if (synced[ch] == level_q[ch]) begin
                    filt_cnt[ch] <= '0;
                end else if (flip[ch]) begin
                    filt_cnt[ch] <= '0;
                    level_q[ch]  <= ~level_q[ch];
                end else begin
                    filt_cnt[ch] <= filt_cnt[ch] + 1'b1;
                end
            end
        end
    end

    assign fg_level    = level_q[CH_FG];
    assign fg_rise     = rise_q[CH_FG];
    assign phase_level = level_q[CH_PHASE];
    assign phase_rise  = rise_q[CH_PHASE];

    // -------------------------------------------------------------------------
    // Period measurement and loss watchdog
    // -------------------------------------------------------------------------
    logic [PERIOD_W-1:0] pcnt;
    logic [LCNT_W-1:0]   lcnt;
    logic                armed;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pcnt         <= '0;
            lcnt         <= '0;
            armed        <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            period_sat   <= 1'b0;
            phase_lost   <= 1'b0;
        end else begin
            period_valid <= 1'b0;

            // pcnt is loaded with 1 on the strobe edge, so at the next strobe
            // it holds exactly the number of cycles between the two strobes.
            if (phase_rise) begin
                pcnt  <= PCNT_ONE;
                armed <= 1'b1;
                // A rise with no valid reference (first after reset or after
                // loss) only arms the measurement.
                if (armed && !phase_lost) begin
                    period       <= pcnt;
                    period_sat   <= (pcnt == PCNT_MAX);
                    period_valid <= 1'b1;
                end
            end else if (pcnt != PCNT_MAX) begin
                pcnt <= pcnt + 1'b1;
            end

            // Watchdog: a rise always wins over an expiring count.
            if (phase_rise_evt) begin
                lcnt       <= '0;
                phase_lost <= 1'b0;
            end else if (lcnt != LCNT_TOP) begin
                lcnt <= lcnt + 1'b1;
                if (lcnt == LCNT_PRE) begin
                    phase_lost <= 1'b1;
                    // Losing the signal invalidates the previous reference.
                    armed      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_calib_input_conditioner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_calib_input_conditioner
//
// Two instances share the inputs: dut_w (24-bit period, 3000-cycle timeout)
// and dut_n (8-bit period, 500-cycle timeout). A reference model works from
// the pin history: the filtered level flips once the last FILTER_LEN synced
// samples all disagree with it, periods are differences of strobe times, and
// loss is elapsed time since the last rise.
// -----------------------------------------------------------------------------
module tb_calib_input_conditioner;

    localparam int S    = 2;
    localparam int F    = 8;
    localparam int TO_W = 3000;
    localparam int TO_N = 500;
    localparam int PW_W = 24;
    localparam int PW_N = 8;
    localparam int HIST = 32768;

    // ---------------- clock / reset ----------------
    logic clock    = 1'b0;
    logic reset_n  = 1'b0;
    logic fg_in    = 1'b0;
    logic phase_in = 1'b0;

    always #5 clock = ~clock;

    logic            fg_level_w, fg_rise_w, phase_level_w, phase_rise_w;
    logic [PW_W-1:0] period_w;
    logic            period_valid_w, period_sat_w, phase_lost_w;
    logic            fg_level_n, fg_rise_n, phase_level_n, phase_rise_n;
    logic [PW_N-1:0] period_n;
    logic            period_valid_n, period_sat_n, phase_lost_n;

    calib_input_conditioner #(
        .SYNC_STAGES(S), .FILTER_LEN(F), .PERIOD_W(PW_W), .TIMEOUT(TO_W)
    ) dut_w (
        .clock(clock), .reset_n(reset_n), .fg_in(fg_in), .phase_in(phase_in),
        .fg_level(fg_level_w), .fg_rise(fg_rise_w),
        .phase_level(phase_level_w), .phase_rise(phase_rise_w),
        .period(period_w), .period_valid(period_valid_w),
        .period_sat(period_sat_w), .phase_lost(phase_lost_w)
    );

    calib_input_conditioner #(
        .SYNC_STAGES(S), .FILTER_LEN(F), .PERIOD_W(PW_N), .TIMEOUT(TO_N)
    ) dut_n (
        .clock(clock), .reset_n(reset_n), .fg_in(fg_in), .phase_in(phase_in),
        .fg_level(fg_level_n), .fg_rise(fg_rise_n),
        .phase_level(phase_level_n), .phase_rise(phase_rise_n),
        .period(period_n), .period_valid(period_valid_n),
        .period_sat(period_sat_n), .phase_lost(phase_lost_n)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            if (n_errors <= 50)
                $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit pin_hist [2][HIST];
    int m_e;
    bit m_level [2];
    bit m_rise  [2];
    int m_period [2];
    bit m_pv [2];
    bit m_sat [2];
    bit m_lost [2];
    bit m_armed [2];
    int m_last_pedge [2];
    int m_last_clear [2];

    function automatic bit m_synced(input int ch, input int e);
        int i;
        i = e - S;
        if (i < 1) return 1'b0;
        return pin_hist[ch][i];
    endfunction

    function automatic int to_of(input int d);
        return (d == 0) ? TO_W : TO_N;
    endfunction

    function automatic int max_of(input int d);
        return (d == 0) ? ((1 << PW_W) - 1) : ((1 << PW_N) - 1);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_e = 0;
            for (int i = 0; i < 2; i++) begin
                m_level[i] = 0; m_rise[i] = 0; m_period[i] = 0; m_pv[i] = 0;
                m_sat[i] = 0; m_lost[i] = 0; m_armed[i] = 0;
                m_last_pedge[i] = 0; m_last_clear[i] = 0;
            end
        end else begin
            m_e = m_e + 1;
            pin_hist[0][m_e] = fg_in;
            pin_hist[1][m_e] = phase_in;
            // period reporting reacts to the strobe visible before this edge
            for (int d = 0; d < 2; d++) begin
                m_pv[d] = 0;
                if (m_rise[1]) begin
                    if (m_armed[d] && !m_lost[d]) begin
                        int diff;
                        diff = m_e - m_last_pedge[d];
                        m_period[d] = (diff > max_of(d)) ? max_of(d) : diff;
                        m_sat[d]    = (diff >= max_of(d));
                        m_pv[d]     = 1;
                    end
                    m_armed[d]      = 1;
                    m_last_pedge[d] = m_e;
                end
            end
            // filtered levels and rise strobes
            for (int ch = 0; ch < 2; ch++) begin
                bit fl;
                fl = (m_e >= F);
                for (int k = 0; k < F; k++)
                    if (m_synced(ch, m_e - k) == m_level[ch]) fl = 0;
                m_rise[ch] = fl && !m_level[ch];
                if (fl) m_level[ch] = !m_level[ch];
            end
            // loss watchdog
            for (int d = 0; d < 2; d++) begin
                if (m_rise[1]) begin
                    m_last_clear[d] = m_e;
                    m_lost[d]       = 0;
                end else if (!m_lost[d] && (m_e - m_last_clear[d] >= to_of(d))) begin
                    m_lost[d]  = 1;
                    m_armed[d] = 0;
                end
            end
        end
    end

    task automatic check_all();
        check_eq("fg_level_w",    fg_level_w,    m_level[0]);
        check_eq("fg_rise_w",     fg_rise_w,     m_rise[0]);
        check_eq("phase_level_w", phase_level_w, m_level[1]);
        check_eq("phase_rise_w",  phase_rise_w,  m_rise[1]);
        check_eq("fg_level_n",    fg_level_n,    m_level[0]);
        check_eq("fg_rise_n",     fg_rise_n,     m_rise[0]);
        check_eq("phase_level_n", phase_level_n, m_level[1]);
        check_eq("phase_rise_n",  phase_rise_n,  m_rise[1]);
        check_eq("period_w",      period_w,       m_period[0]);
        check_eq("period_valid_w", period_valid_w, m_pv[0]);
        check_eq("period_sat_w",  period_sat_w,   m_sat[0]);
        check_eq("phase_lost_w",  phase_lost_w,   m_lost[0]);
        check_eq("period_n",      period_n,       m_period[1]);
        check_eq("period_valid_n", period_valid_n, m_pv[1]);
        check_eq("period_sat_n",  period_sat_n,   m_sat[1]);
        check_eq("phase_lost_n",  phase_lost_n,   m_lost[1]);
    endtask

    // ---------------- driver tasks ----------------
    int cnt_fg, cnt_ph, cnt_pv_w, cnt_pv_n;

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            check_all();
            if (fg_rise_w)      cnt_fg++;
            if (phase_rise_w)   cnt_ph++;
            if (period_valid_w) cnt_pv_w++;
            if (period_valid_n) cnt_pv_n++;
        end
    endtask

    task automatic clear_counts();
        cnt_fg = 0; cnt_ph = 0; cnt_pv_w = 0; cnt_pv_n = 0;
    endtask

    task automatic phase_pulse(input int hi, input int lo);
        phase_in = 1'b1;
        tick(hi);
        phase_in = 1'b0;
        tick(lo);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int k;
        bit seen;

        // 1. reset with toggling inputs, then fg latency
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            fg_in    = 1'($urandom_range(0, 1));
            phase_in = 1'($urandom_range(0, 1));
        end
        @(negedge clock);
        check_all();
        check_eq("rst_fg_level",    fg_level_w,     0);
        check_eq("rst_phase_level", phase_level_w,  0);
        check_eq("rst_period",      period_w,       0);
        check_eq("rst_pv",          period_valid_w, 0);
        check_eq("rst_lost",        phase_lost_n,   0);
        check_eq("rst_sat",         period_sat_n,   0);

        clear_counts();
        fg_in    = 1'b1;
        phase_in = 1'b0;
        reset_n  = 1'b1;
        lat  = 0;
        seen = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (fg_level_w && !seen) begin
                seen = 1;
                lat  = i;
                check_eq("fg_rise_with_level", fg_rise_w, 1);
            end
        end
        check_eq("fg_latency", lat, S + F);
        check_eq("fg_rise_count", cnt_fg, 1);
        fg_in = 1'b0;
        tick(15);
        check_eq("fg_fall_level", fg_level_w, 0);
        check_eq("fg_no_fall_strobe", cnt_fg, 1);

        // 2. glitch rejection
        clear_counts();
        phase_pulse(7, 20);
        check_eq("glitch7_rises", cnt_ph, 0);
        check_eq("glitch7_level", phase_level_w, 0);
        phase_pulse(8, 20);
        check_eq("pulse8_rises", cnt_ph, 1);

        // 3. period 1000, starting from a lost state on both instances
        tick(3100);
        check_eq("idle_lost_w", phase_lost_w, 1);
        clear_counts();
        for (int i = 0; i < 4; i++) phase_pulse(20, 980);
        check_eq("p1000_valid_count", cnt_pv_w, 3);
        check_eq("p1000_period", period_w, 1000);
        check_eq("p1000_sat", period_sat_w, 0);
        check_eq("p1000_narrow_never_valid", cnt_pv_n, 0);

        // 4. saturation on the 8-bit instance
        tick(600);
        clear_counts();
        for (int i = 0; i < 5; i++) phase_pulse(20, 280);
        check_eq("sat_valid_count", cnt_pv_n, 4);
        check_eq("sat_period_n", period_n, 255);
        check_eq("sat_flag_n", period_sat_n, 1);
        check_eq("wide_period_300", period_w, 300);
        check_eq("wide_sat_0", period_sat_w, 0);

        // 5. loss watchdog timing and recovery
        tick(600);
        check_eq("pre_lost_n", phase_lost_n, 1);
        clear_counts();
        phase_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick(1);
            if (phase_rise_n) seen = 1;
        end
        check_eq("rise_seen", seen, 1);
        check_eq("rise_clears_lost", phase_lost_n, 0);
        tick(20);
        phase_in = 1'b0;
        k = 20;
        seen = 0;
        while (!seen && k < 1000) begin
            tick(1);
            k++;
            if (phase_lost_n) seen = 1;
        end
        check_eq("lost_seen", seen, 1);
        check_eq("lost_latency", k, TO_N);
        check_eq("no_pv_after_lost", cnt_pv_n, 0);
        phase_pulse(20, 180);
        check_eq("first_after_lost_no_pv", cnt_pv_n, 0);
        check_eq("lost_cleared", phase_lost_n, 0);
        phase_pulse(20, 180);
        check_eq("recover_pv", cnt_pv_n, 1);
        check_eq("recover_period", period_n, 200);
        check_eq("recover_sat", period_sat_n, 0);

        // 6. asynchronous reset mid-filter
        phase_in = 1'b1;
        fg_in    = 1'b0;
        tick(15);
        check_eq("pre_rst_phase_level", phase_level_w, 1);
        fg_in = 1'b1;
        tick(5);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_fg_level",    fg_level_w,     0);
        check_eq("arst_phase_level", phase_level_w,  0);
        check_eq("arst_phase_lvl_n", phase_level_n,  0);
        check_eq("arst_period_w",    period_w,       0);
        check_eq("arst_period_n",    period_n,       0);
        check_eq("arst_pv",          period_valid_w, 0);
        check_eq("arst_lost",        phase_lost_n,   0);
        check_eq("arst_sat",         period_sat_w,   0);
        fg_in    = 1'b0;
        phase_in = 1'b0;
        tick(3);
        reset_n = 1'b1;
        clear_counts();
        tick(40);
        check_eq("post_rst_fg_rise", cnt_fg, 0);
        check_eq("post_rst_ph_rise", cnt_ph, 0);
        check_eq("post_rst_pv", cnt_pv_w + cnt_pv_n, 0);

        // 7. randomized segments against the model
        for (int i = 0; i < 150; i++) begin
            fg_in    = 1'($urandom_range(0, 1));
            phase_in = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 30));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
